pixel_stream_proc: RTL
======================

# pixel_stream_proc

Parametrised streaming RGB pixel processor that replaces fixed-function per-frame image operations with a valid/ready pipeline. It sits between the image reader and image writer and applies one selectable operation to every pixel of a frame: pass, saturating brightness, grayscale, invert, or optional threshold. Each output pixel carries its row/column coordinate and an end-of-frame flag. The block sustains one pixel per clock with back-pressure.

## Interface
- DW, 8, bits per colour channel (4..12)
- CW, 11, bits of row/col coordinate and frame dimensions
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high reset
- opcode  in  3  operation select, sampled at frame start
- cfg_delta  in  DW+1  signed brightness offset, sampled at frame start
- cfg_thresh  in  DW  threshold level, sampled at frame start
- width / height  in  CW  frame size, sampled at frame start; 0 treated as 1
- in_valid / in_ready  in / out  1  input handshake
- in_r, in_g, in_b  in  DW  input pixel
- out_valid / out_ready  out / in  1  output handshake
- out_r, out_g, out_b  out  DW  processed pixel
- out_row, out_col  out  CW  coordinate of the output pixel
- out_eof  out  1  high with the last pixel of a frame
- busy  out  1  frame in progress (first pixel accepted, last not yet output)

## Operation
- Opcodes: 0 PASS, 1 BRIGHT, 2 GRAY, 3 INVERT, 4 THRESH, 5–7 PASS.
- BRIGHT: each channel is x + cfg_delta, clamped to [0, 2^DW−1].
- GRAY: y = (77·R + 150·G + 29·B) >> 8, with DW+8-bit intermediate and truncation. y is written to all three channels.
- INVERT: each channel is (2^DW−1) − x.
- THRESH: y computed as for GRAY. All channels are 2^DW−1 if y ≥ cfg_thresh, else 0.
- Frame start is the input handshake when the internal input counters are at (0,0). On that handshake, opcode, cfg_delta, cfg_thresh, width and height are latched. Later changes to these inputs take effect only at the next frame.
- Input counters: col increments on each input handshake. col wraps at width−1 and row then increments. After (height−1, width−1) both counters return to 0.
- The coordinate and eof flag are pipelined alongside the pixel data.
- Per-pixel arithmetic is combinational in stage 1. Stage 2 is the output register.

## Timing
- Two-stage pipeline. Latency is 2 cycles from input handshake to out_valid when out_ready is held high. Throughput is 1 pixel/clock.
- Global advance: en = !v2 | out_ready.
- in_ready = en. This is a combinational path from out_ready; no other combinational in→out path exists.
- When en = 0, stage contents hold and out_* remain stable while out_valid = 1.
- out_valid must not drop until a handshake completes.
- Reset values: out_valid=0, out_r/g/b=0, out_row=out_col=0, out_eof=0, busy=0. in_ready=1 in the first cycle after reset.
- Reset mid-frame: pipeline contents are discarded without being output, counters clear, and the next accepted pixel starts a new frame.
- busy rises on the frame-start handshake. busy falls on the out_eof handshake. If a new frame-start handshake occurs in the same cycle as the out_eof handshake, busy stays 1.
- 1×1 frame (or width=height=0): the first pixel carries out_eof=1, at row 0, col 0.

## Configuration
- PIXEL_STREAM_THRESH_EN defined: opcode 4 performs THRESH and the cfg_thresh comparator is built.
- Not defined: opcode 4 behaves as PASS, cfg_thresh is ignored, and no comparator logic is built.

## Structure
- Shared package image_proc_pkg holds:
  - opcode constants (OP_PASS, OP_BRIGHT, OP_GRAY, OP_INVERT, OP_THRESH);
  - luma weights 77/150/29 and shift 8.
- One sub-module, pixel_alu: purely combinational, parametrised by DW. It maps (op, delta, thresh, r, g, b) to (r', g', b').
- Counters, latching and the pipeline live in the top module.

## Test plan
- DW=8, 4×2 frame, BRIGHT delta=+100, pixel (200,50,0) → (255,150,100). out_eof only on the 8th output, at row 1, col 3.
- BRIGHT delta=−60, pixel (30,60,255) → (0,0,195).
- GRAY, pixel (255,0,0) → (76,76,76). Pixel (255,255,255) → (255,255,255).
- Opcode changes from INVERT to PASS after the 2nd pixel of a 3×1 frame → all 3 pixels inverted. The next frame is PASS.
- out_ready low for 5 cycles with continuous input → in_ready low within 1 cycle. No pixel is dropped or duplicated, and outputs are stable while stalled. With out_ready held high, 2-cycle latency.
- THRESH=128 with macro defined: pixel (128,128,128) → (255,255,255). Without the macro, the same pixel passes unchanged. Reset asserted mid-frame → out_valid=0 the next cycle and the next pixel is output at (0,0).

Source files
------------

// File: rtl/pixel_stream_proc_pkg.sv
// Shared constants for the image pipeline: opcode encodings and luma weights.
// Optional feature macro: PIXEL_STREAM_THRESH_EN (see pixel_alu / pixel_stream_proc).
package image_proc_pkg;

    typedef enum logic [2:0] {
        OP_PASS   = 3'd0,
        OP_BRIGHT = 3'd1,
        OP_GRAY   = 3'd2,
        OP_INVERT = 3'd3,
        OP_THRESH = 3'd4
    } op_e;

    // ITU-R BT.601 weights scaled by 256
    localparam int unsigned LUMA_R     = 77;
    localparam int unsigned LUMA_G     = 150;
    localparam int unsigned LUMA_B     = 29;
    localparam int unsigned LUMA_SHIFT = 8;

endpackage

// File: rtl/pixel_stream_proc_if.sv
// Valid/ready pixel stream bundle: input pixel channel plus output pixel channel with coordinates.
// Optional feature macro: PIXEL_STREAM_THRESH_EN (not used here).
interface pixel_stream_proc_if #(
    parameter int DW = 8,
    parameter int CW = 11
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_r;
    logic [DW-1:0] in_g;
    logic [DW-1:0] in_b;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_r;
    logic [DW-1:0] out_g;
    logic [DW-1:0] out_b;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          out_eof;

    modport master (
        output in_valid, in_r, in_g, in_b, out_ready,
        input  in_ready, out_valid, out_r, out_g, out_b, out_row, out_col, out_eof
    );

    modport slave (
        input  in_valid, in_r, in_g, in_b, out_ready,
        output in_ready, out_valid, out_r, out_g, out_b, out_row, out_col, out_eof
    );
endinterface

// File: rtl/pixel_stream_proc_alu.sv
// pixel_alu: combinational per-pixel operation (pass, saturating brightness, gray, invert, threshold).
// PIXEL_STREAM_THRESH_EN builds the threshold comparator; otherwise opcode 4 passes through.
module pixel_alu
    import image_proc_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [2:0]       op_i,
    input  logic signed [DW:0] delta_i,
    input  logic [DW-1:0]    thresh_i,
    input  logic [DW-1:0]    r_i,
    input  logic [DW-1:0]    g_i,
    input  logic [DW-1:0]    b_i,
    output logic [DW-1:0]    r_o,
    output logic [DW-1:0]    g_o,
    output logic [DW-1:0]    b_o
);
    localparam logic [DW-1:0] MAXV = '1;

    logic [DW+7:0] luma_sum;
    logic [DW-1:0] luma;

    // Sum fits in DW+2 bits; top bit flags negative, next bit flags overflow
    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] x, input logic signed [DW:0] d);
        logic [DW+1:0] s;
        s = {2'b00, x} + {d[DW], d};
        if (s[DW+1])
            return '0;
        else if (s[DW])
            return MAXV;
        else
            return s[DW-1:0];
    endfunction

    assign luma_sum = (DW+8)'(LUMA_R) * (DW+8)'(r_i)
                    + (DW+8)'(LUMA_G) * (DW+8)'(g_i)
                    + (DW+8)'(LUMA_B) * (DW+8)'(b_i);
    assign luma     = DW'(luma_sum >> LUMA_SHIFT);

`ifndef PIXEL_STREAM_THRESH_EN
    logic unused_thresh;
    assign unused_thresh = ^thresh_i;
`endif

    always_comb begin
        r_o = r_i;
        g_o = g_i;
        b_o = b_i;
        case (op_i)
            OP_BRIGHT: begin
                r_o = sat_add(r_i, delta_i);
                g_o = sat_add(g_i, delta_i);
                b_o = sat_add(b_i, delta_i);
            end
            OP_GRAY: begin
                r_o = luma;
                g_o = luma;
                b_o = luma;
            end
            OP_INVERT: begin
                r_o = MAXV - r_i;
                g_o = MAXV - g_i;
                b_o = MAXV - b_i;
            end
`ifdef PIXEL_STREAM_THRESH_EN
            OP_THRESH: begin
                r_o = (luma >= thresh_i) ? MAXV : '0;
                g_o = (luma >= thresh_i) ? MAXV : '0;
                b_o = (luma >= thresh_i) ? MAXV : '0;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: rtl/pixel_stream_proc.sv
// Two-stage valid/ready RGB pixel processor with per-frame latched configuration and coordinates.
// PIXEL_STREAM_THRESH_EN enables the threshold operation inside pixel_alu.
module pixel_stream_proc
    import image_proc_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 11
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [2:0]         opcode_i,
    input  logic signed [DW:0] cfg_delta_i,
    input  logic [DW-1:0]      cfg_thresh_i,
    input  logic [CW-1:0]      width_i,
    input  logic [CW-1:0]      height_i,
    output logic               busy_o,
    pixel_stream_proc_if.slave px
);
    logic en, hs_in, at_origin, frame_start, last_col, last_row;
    logic [CW-1:0] col_q, row_q, col_d, row_d;
    logic [CW-1:0] width_q, height_q, w_cur, h_cur;
    logic [2:0]    op_q;
    logic signed [DW:0] delta_q;
    logic [DW-1:0] thresh_q;

    logic          v1_q, eof1_q, v2_q, eof2_q, busy_q;
    logic [DW-1:0] r1_q, g1_q, b1_q, r2_q, g2_q, b2_q;
    logic [CW-1:0] row1_q, col1_q, row2_q, col2_q;
    logic [DW-1:0] alu_r, alu_g, alu_b;

    function automatic logic [CW-1:0] at_least_one(input logic [CW-1:0] v);
        return (v == '0) ? CW'(1) : v;
    endfunction

    assign en          = !v2_q || px.out_ready;
    assign hs_in       = px.in_valid && en;
    assign at_origin   = (row_q == '0) && (col_q == '0);
    assign frame_start = hs_in && at_origin;
    // The first pixel of a frame must already see the new frame size
    assign w_cur       = at_origin ? at_least_one(width_i)  : width_q;
    assign h_cur       = at_origin ? at_least_one(height_i) : height_q;
    assign last_col    = (col_q == w_cur - CW'(1));
    assign last_row    = (row_q == h_cur - CW'(1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (hs_in) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    pixel_alu #(.DW(DW)) u_alu (
        .op_i     (op_q),
        .delta_i  (delta_q),
        .thresh_i (thresh_q),
        .r_i      (r1_q),
        .g_i      (g1_q),
        .b_i      (b1_q),
        .r_o      (alu_r),
        .g_o      (alu_g),
        .b_o      (alu_b)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q    <= '0;
            row_q    <= '0;
            width_q  <= CW'(1);
            height_q <= CW'(1);
            op_q     <= OP_PASS;
            delta_q  <= '0;
            thresh_q <= '0;
            v1_q     <= 1'b0;
            r1_q     <= '0;
            g1_q     <= '0;
            b1_q     <= '0;
            row1_q   <= '0;
            col1_q   <= '0;
            eof1_q   <= 1'b0;
            v2_q     <= 1'b0;
            r2_q     <= '0;
            g2_q     <= '0;
            b2_q     <= '0;
            row2_q   <= '0;
            col2_q   <= '0;
            eof2_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (frame_start) begin
                op_q     <= opcode_i;
                delta_q  <= cfg_delta_i;
                thresh_q <= cfg_thresh_i;
                width_q  <= at_least_one(width_i);
                height_q <= at_least_one(height_i);
            end
            if (en) begin
                v1_q <= px.in_valid;
                if (px.in_valid) begin
                    r1_q   <= px.in_r;
                    g1_q   <= px.in_g;
                    b1_q   <= px.in_b;
                    row1_q <= row_q;
                    col1_q <= col_q;
                    eof1_q <= last_col && last_row;
                end
                v2_q <= v1_q;
                if (v1_q) begin
                    r2_q   <= alu_r;
                    g2_q   <= alu_g;
                    b2_q   <= alu_b;
                    row2_q <= row1_q;
                    col2_q <= col1_q;
                    eof2_q <= eof1_q;
                end
            end
            // A new frame starting on the same edge as the old one ending keeps busy high
            if (frame_start)
                busy_q <= 1'b1;
            else if (v2_q && px.out_ready && eof2_q)
                busy_q <= 1'b0;
        end
    end

    assign px.in_ready  = en;
    assign px.out_valid = v2_q;
    assign px.out_r     = r2_q;
    assign px.out_g     = g2_q;
    assign px.out_b     = b2_q;
    assign px.out_row   = row2_q;
    assign px.out_col   = col2_q;
    assign px.out_eof   = eof2_q;
    assign busy_o       = busy_q;
endmodule
